// File: rtl/regblock_cpuif_arb2_if.sv
// regblock_cpuif_arb2_if
//   Bundles every bus signal of the two-requester CPU-interface arbiter:
//   two requester ports (m0_*, m1_*) and the shared regblock cpuif_* bus.
//   Modports:
//     slave  - the arbiter: serves the requesters and drives the regblock bus.
//     master - the environment: requesters plus regblock responses.
//   Params: ADDR_WIDTH (address width), DATA_WIDTH (data/bit-enable width).
interface regblock_cpuif_arb2_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // requester 0
  logic                  m0_req;
  logic                  m0_is_wr;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wr_data;
  logic [DATA_WIDTH-1:0] m0_wr_biten;
  logic                  m0_gnt;
  logic                  m0_ack;
  logic                  m0_err;
  logic [DATA_WIDTH-1:0] m0_rd_data;
  // requester 1
  logic                  m1_req;
  logic                  m1_is_wr;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wr_data;
  logic [DATA_WIDTH-1:0] m1_wr_biten;
  logic                  m1_gnt;
  logic                  m1_ack;
  logic                  m1_err;
  logic [DATA_WIDTH-1:0] m1_rd_data;
  // regblock side
  logic                  cpuif_req;
  logic                  cpuif_req_is_wr;
  logic [ADDR_WIDTH-1:0] cpuif_addr;
  logic [DATA_WIDTH-1:0] cpuif_wr_data;
  logic [DATA_WIDTH-1:0] cpuif_wr_biten;
  logic                  cpuif_req_stall_wr;
  logic                  cpuif_req_stall_rd;
  logic                  cpuif_rd_ack;
  logic                  cpuif_rd_err;
  logic [DATA_WIDTH-1:0] cpuif_rd_data;
  logic                  cpuif_wr_ack;
  logic                  cpuif_wr_err;

  modport slave (
    input  m0_req, m0_is_wr, m0_addr, m0_wr_data, m0_wr_biten,
    output m0_gnt, m0_ack, m0_err, m0_rd_data,
    input  m1_req, m1_is_wr, m1_addr, m1_wr_data, m1_wr_biten,
    output m1_gnt, m1_ack, m1_err, m1_rd_data,
    output cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten,
    input  cpuif_req_stall_wr, cpuif_req_stall_rd,
    input  cpuif_rd_ack, cpuif_rd_err, cpuif_rd_data, cpuif_wr_ack, cpuif_wr_err
  );

  modport master (
    output m0_req, m0_is_wr, m0_addr, m0_wr_data, m0_wr_biten,
    input  m0_gnt, m0_ack, m0_err, m0_rd_data,
    output m1_req, m1_is_wr, m1_addr, m1_wr_data, m1_wr_biten,
    input  m1_gnt, m1_ack, m1_err, m1_rd_data,
    input  cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten,
    output cpuif_req_stall_wr, cpuif_req_stall_rd,
    output cpuif_rd_ack, cpuif_rd_err, cpuif_rd_data, cpuif_wr_ack, cpuif_wr_err
  );
endinterface

// File: rtl/regblock_cpuif_arb2.sv
// regblock_cpuif_arb2
//   Shares one regblock CPU interface between two requesters. Round-robin
//   selection on ties, one transaction in flight, response routed to owner.
//   Ports:
//     clk    - rising-edge clock
//     arst_n - asynchronous active-low reset
//     bus    - regblock_cpuif_arb2_if.slave (m0_*, m1_*, cpuif_*)
//   Params: ADDR_WIDTH, DATA_WIDTH, TIMEOUT_CYCLES (>= 2).
//   Option macro CPUIF_ARB_TIMEOUT_EN: when defined, a WAIT that sees no ack
//   for TIMEOUT_CYCLES cycles is closed with an error ack to the owner.
module regblock_cpuif_arb2 #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  arst_n,
  regblock_cpuif_arb2_if.slave  bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state, state_nxt;

  // requester views, index = master number
  logic [1:0]                 m_req, m_is_wr;
  logic [1:0][ADDR_WIDTH-1:0] m_addr;
  logic [1:0][DATA_WIDTH-1:0] m_wr_data, m_wr_biten;

  assign m_req      = {bus.m1_req,      bus.m0_req};
  assign m_is_wr    = {bus.m1_is_wr,    bus.m0_is_wr};
  assign m_addr     = {bus.m1_addr,     bus.m0_addr};
  assign m_wr_data  = {bus.m1_wr_data,  bus.m0_wr_data};
  assign m_wr_biten = {bus.m1_wr_biten, bus.m0_wr_biten};

  // latched request
  logic                  owner, last_gnt;
  logic                  req_is_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wr_data, req_wr_biten;

  logic       sel, latch, resp, tmo, cpuif_req_c;
  logic [1:0] gnt;
  logic       stall, ack_match;

  assign stall     = req_is_wr ? bus.cpuif_req_stall_wr : bus.cpuif_req_stall_rd;
  assign ack_match = req_is_wr ? bus.cpuif_wr_ack       : bus.cpuif_rd_ack;

`ifdef CPUIF_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // counter holds (WAIT cycles seen - 1), so it hits on the Nth WAIT cycle
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)               tmo_cnt <= '0;
    else if (state != S_WAIT)  tmo_cnt <= '0;
    else                       tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    sel         = owner;
    latch       = 1'b0;
    gnt         = '0;
    resp        = 1'b0;
    tmo         = 1'b0;
    cpuif_req_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (|m_req) begin
          latch     = 1'b1;
          // tie goes to whoever was not granted last
          sel       = (&m_req) ? ~last_gnt : m_req[1];
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cpuif_req_c = 1'b1;
        // acks are only meaningful once the request is actually accepted
        if (!stall) begin
          gnt[owner] = 1'b1;
          resp       = ack_match;
          state_nxt  = ack_match ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack_match) begin
          resp      = 1'b1;
          state_nxt = S_IDLE;
        end else if (tmo_hit) begin
          resp      = 1'b1;
          tmo       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= S_IDLE;
      owner        <= 1'b0;
      last_gnt     <= 1'b1;
      req_is_wr    <= 1'b0;
      req_addr     <= '0;
      req_wr_data  <= '0;
      req_wr_biten <= '0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        owner        <= sel;
        req_is_wr    <= m_is_wr[sel];
        req_addr     <= m_addr[sel];
        req_wr_data  <= m_wr_data[sel];
        req_wr_biten <= m_wr_biten[sel];
      end
      if (|gnt) last_gnt <= owner;
    end
  end

  // response path is combinational from the regblock acks
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_data;
  logic [1:0]            ack;

  assign resp_err  = tmo | (req_is_wr ? bus.cpuif_wr_err : bus.cpuif_rd_err);
  assign resp_data = (resp && !req_is_wr && !tmo) ? bus.cpuif_rd_data : '0;
  assign ack       = {resp & owner, resp & ~owner};

  assign bus.m0_gnt     = gnt[0];
  assign bus.m1_gnt     = gnt[1];
  assign bus.m0_ack     = ack[0];
  assign bus.m1_ack     = ack[1];
  assign bus.m0_err     = ack[0] & resp_err;
  assign bus.m1_err     = ack[1] & resp_err;
  assign bus.m0_rd_data = ack[0] ? resp_data : '0;
  assign bus.m1_rd_data = ack[1] ? resp_data : '0;

  assign bus.cpuif_req       = cpuif_req_c;
  assign bus.cpuif_req_is_wr = req_is_wr;
  assign bus.cpuif_addr      = req_addr;
  assign bus.cpuif_wr_data   = req_wr_data;
  assign bus.cpuif_wr_biten  = req_wr_biten;

endmodule

// File: tb/tb_regblock_cpuif_arb2.sv
// Bench for regblock_cpuif_arb2: per-cycle vector table plus hand sequences
// for async reset mid-transaction and (with CPUIF_ARB_TIMEOUT_EN) timeout.
module tb_regblock_cpuif_arb2;
`ifdef CPUIF_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  regblock_cpuif_arb2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  regblock_cpuif_arb2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
  localparam logic [31:0] Z = 32'h0;

  typedef struct {
    logic [1:0]  req;  logic [1:0] wr; logic [31:0] a0; logic [31:0] a1;
    logic stw; logic str; logic rack; logic rerr; logic [31:0] rdat; logic wack; logic werr;
    logic creq; logic cwr; logic [31:0] caddr; logic [31:0] cwd; logic [31:0] cbe;
    logic [1:0] gnt; logic [1:0] ack; logic [1:0] err; logic [31:0] rd0; logic [31:0] rd1;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [167:0] snap();
    return {bus.cpuif_req, bus.cpuif_req_is_wr, bus.cpuif_addr, bus.cpuif_wr_data,
            bus.cpuif_wr_biten, bus.m1_gnt, bus.m0_gnt, bus.m1_ack, bus.m0_ack,
            bus.m1_err, bus.m0_err, bus.m0_rd_data, bus.m1_rd_data};
  endfunction

  task automatic check(input string name, input logic [167:0] act, input logic [167:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.m0_req = v.req[0];  bus.m1_req = v.req[1];
    bus.m0_is_wr = v.wr[0]; bus.m1_is_wr = v.wr[1];
    bus.m0_addr = v.a0;     bus.m1_addr = v.a1;
    bus.m0_wr_data = ~v.a0; bus.m0_wr_biten = 32'hFFFF_FFFF;
    bus.m1_wr_data = v.a1 ^ 32'h5A5A_5A5A; bus.m1_wr_biten = 32'h00FF_00FF;
    bus.cpuif_req_stall_wr = v.stw; bus.cpuif_req_stall_rd = v.str;
    bus.cpuif_rd_ack = v.rack; bus.cpuif_rd_err = v.rerr; bus.cpuif_rd_data = v.rdat;
    bus.cpuif_wr_ack = v.wack; bus.cpuif_wr_err = v.werr;
  endtask

  vec_t idle_v;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [167:0] act, exp;
    vec_t v;

    idle_v = vec_t'{2'b00,2'b00,Z,Z, O,O,O,O,Z,O,O, O,O,Z,Z,Z,2'b00,2'b00,2'b00,Z,Z};

    // single read, m0 @0x10
    tbl.push_back(vec_t'{2'b01,2'b00,32'h10,Z, O,O,O,O,Z,O,O, O,O,Z,Z,Z,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b01,2'b00,32'h10,Z, O,O,O,O,Z,O,O, I,O,32'h10,Z,Z,2'b01,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,Z,Z, O,O,I,O,32'hDEADBEEF,O,O, O,O,Z,Z,Z,2'b00,2'b01,2'b00,32'hDEADBEEF,Z});
    // m1 read error, then a clean m1 read
    tbl.push_back(vec_t'{2'b10,2'b00,Z,32'hFFC, O,O,O,O,Z,O,O, O,O,Z,Z,Z,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b00,Z,32'hFFC, O,O,O,O,Z,O,O, I,O,32'hFFC,Z,Z,2'b10,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,Z,Z, O,O,I,I,32'h0BAD0BAD,O,O, O,O,Z,Z,Z,2'b00,2'b10,2'b10,Z,32'h0BAD0BAD});
    tbl.push_back(vec_t'{2'b10,2'b00,Z,32'h20, O,O,O,O,Z,O,O, O,O,Z,Z,Z,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b00,Z,32'h20, O,O,O,O,Z,O,O, I,O,32'h20,Z,Z,2'b10,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,Z,Z, O,O,I,O,32'h11112222,O,O, O,O,Z,Z,Z,2'b00,2'b10,2'b00,Z,32'h11112222});
    // simultaneous writes: order m0, m1, m0
    tbl.push_back(vec_t'{2'b11,2'b11,32'h4,32'h8, O,O,O,O,Z,O,O, O,O,Z,Z,Z,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b11,2'b11,32'h4,32'h8, O,O,O,O,Z,O,O, I,I,32'h4,32'hFFFFFFFB,32'hFFFFFFFF,2'b01,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b11,2'b11,32'h4,32'h8, O,O,O,O,Z,I,O, O,O,Z,Z,Z,2'b00,2'b01,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b11,2'b11,32'h4,32'h8, O,O,O,O,Z,O,O, O,O,Z,Z,Z,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b11,2'b11,32'h4,32'h8, O,O,O,O,Z,O,O, I,I,32'h8,32'h5A5A5A52,32'h00FF00FF,2'b10,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b01,2'b01,32'h4,Z, O,O,O,O,Z,I,O, O,O,Z,Z,Z,2'b00,2'b10,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b01,2'b01,32'h4,Z, O,O,O,O,Z,O,O, O,O,Z,Z,Z,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b01,2'b01,32'h4,Z, O,O,O,O,Z,O,O, I,I,32'h4,32'hFFFFFFFB,32'hFFFFFFFF,2'b01,2'b00,2'b00,Z,Z});
    // wrong-direction ack ignored, then write error, then stray ack in IDLE
    tbl.push_back(vec_t'{2'b00,2'b00,Z,Z, O,O,I,O,32'hFFFFFFFF,O,O, O,O,Z,Z,Z,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,Z,Z, O,O,O,O,Z,I,I, O,O,Z,Z,Z,2'b00,2'b01,2'b01,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,Z,Z, O,O,O,O,Z,I,O, O,O,Z,Z,Z,2'b00,2'b00,2'b00,Z,Z});
    // m1 write stalled 4 cycles; ack during stall ignored; read stall does not block a write
    tbl.push_back(vec_t'{2'b10,2'b10,Z,32'h30, O,O,O,O,Z,O,O, O,O,Z,Z,Z,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b10,Z,32'h30, I,O,O,O,Z,O,O, I,I,32'h30,32'h5A5A5A6A,32'h00FF00FF,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b10,Z,32'h30, I,O,O,O,Z,O,O, I,I,32'h30,32'h5A5A5A6A,32'h00FF00FF,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b10,Z,32'h30, I,O,O,O,Z,I,O, I,I,32'h30,32'h5A5A5A6A,32'h00FF00FF,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b10,Z,32'h30, I,O,O,O,Z,O,O, I,I,32'h30,32'h5A5A5A6A,32'h00FF00FF,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b10,2'b10,Z,32'h30, O,I,O,O,Z,O,O, I,I,32'h30,32'h5A5A5A6A,32'h00FF00FF,2'b10,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,Z,Z, O,O,O,O,Z,I,O, O,O,Z,Z,Z,2'b00,2'b10,2'b00,Z,Z});
    // ack in the same cycle as the grant
    tbl.push_back(vec_t'{2'b01,2'b00,32'h40,Z, O,O,O,O,Z,O,O, O,O,Z,Z,Z,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b01,2'b00,32'h40,Z, O,O,I,O,32'hCAFEF00D,O,O, I,O,32'h40,Z,Z,2'b01,2'b01,2'b00,32'hCAFEF00D,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,Z,Z, O,O,O,O,Z,O,O, O,O,Z,Z,Z,2'b00,2'b00,2'b00,Z,Z});
    // requester drops req while stalled; transaction still completes
    tbl.push_back(vec_t'{2'b01,2'b00,32'h50,Z, O,O,O,O,Z,O,O, O,O,Z,Z,Z,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,Z,Z, O,I,O,O,Z,O,O, I,O,32'h50,Z,Z,2'b00,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,Z,Z, O,O,O,O,Z,O,O, I,O,32'h50,Z,Z,2'b01,2'b00,2'b00,Z,Z});
    tbl.push_back(vec_t'{2'b00,2'b00,Z,Z, O,O,I,O,32'h00000055,O,O, O,O,Z,Z,Z,2'b00,2'b01,2'b00,32'h00000055,Z});

    // reset state, with activity on the inputs
    v = idle_v; v.req = 2'b11; v.rack = I; v.wack = I; v.rdat = 32'h12345678;
    drive(v);
    #12;
    check("reset_outputs", snap(), '0);
    @(negedge clk);
    drive(idle_v);
    arst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      v = tbl[i];
      drive(v);
      #1;
      act = {bus.cpuif_req, bus.cpuif_req_is_wr & v.creq, bus.cpuif_addr & {32{v.creq}},
             bus.cpuif_wr_data & {32{v.creq & v.cwr}}, bus.cpuif_wr_biten & {32{v.creq & v.cwr}},
             bus.m1_gnt, bus.m0_gnt, bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err,
             bus.m0_rd_data, bus.m1_rd_data};
      exp = {v.creq, v.cwr, v.caddr, v.cwd, v.cbe, v.gnt, v.ack, v.err, v.rd0, v.rd1};
      check($sformatf("vec%0d", i), act, exp);
    end

    // reset asserted while in WAIT
    @(negedge clk);
    v = idle_v; v.req = 2'b01; v.wr = 2'b01; v.a0 = 32'h60;
    drive(v);
    @(negedge clk);
    #1;
    check("rst_seq_issue", {166'd0, bus.cpuif_req, bus.m0_gnt}, {166'd0, 2'b11});
    @(negedge clk);
    drive(idle_v);
    #1;
    arst_n = 1'b0;
    #1;
    check("rst_async", snap(), '0);
    @(negedge clk);
    arst_n = 1'b1;
    v = idle_v; v.wack = I;
    drive(v);
    #1;
    check("rst_stray_ack", snap(), '0);
    @(negedge clk);
    v = idle_v; v.req = 2'b11; v.wr = 2'b11; v.a0 = 32'h70; v.a1 = 32'h80;
    drive(v);
    #1;
    check("rst_tie_idle", snap(), '0);
    @(negedge clk);
    #1;
    check("rst_tie_m0", {133'd0, bus.cpuif_req, bus.cpuif_addr, bus.m1_gnt, bus.m0_gnt},
          {133'd0, 1'b1, 32'h70, 2'b01});
    @(negedge clk);
    v = idle_v; v.wack = I;
    drive(v);
    #1;
    check("rst_tie_ack", {164'd0, bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err},
          {164'd0, 4'b0100});

`ifdef CPUIF_ARB_TIMEOUT_EN
    // timeout: read never acked, late ack in cycle 12 ignored
    @(negedge clk);
    v = idle_v; v.req = 2'b01; v.a0 = 32'h90; v.rdat = 32'h12345678;
    drive(v);
    @(negedge clk);
    #1;
    check("tmo_issue", {166'd0, bus.cpuif_req, bus.m0_gnt}, {166'd0, 2'b11});
    v.req = 2'b00;
    drive(v);
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (k == 12) begin
        v.rack = I;
        drive(v);
      end
      #1;
      if (k == 9)
        check("tmo_fire", {131'd0, bus.m1_ack, bus.m0_ack, bus.m0_err, bus.m0_rd_data, bus.m1_err},
              {131'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0});
      else
        check($sformatf("tmo_quiet%0d", k), {164'd0, bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err},
              168'd0);
    end
    @(negedge clk);
    drive(idle_v);
`endif

    @(negedge clk);
    drive(idle_v);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
